// File: rtl/dif_frame_arbiter.sv
// dif_frame_arbiter
// Round-robin frame arbiter that shares one streaming DIF FFT pipeline between
// two sample sources. Ownership is granted a whole frame (N = 2^FFT_NUM samples)
// at a time. The owner of every granted frame is recorded in a small tag FIFO so
// that pipeline output samples can be labelled with channel, start-of-frame and
// end-of-frame.
//
// Handshake: a source sample moves on a cycle where sX_valid && sX_ready are both
// high. sX_ready is combinational and never depends on the other channel's valid
// while a frame is owned. fft_din_valid is exactly the accepted-beat strobe of the
// current owner. The input path has zero latency.
module dif_frame_arbiter #(
  parameter int FFT_NUM   = 6,
  parameter int DW        = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2*DW-1:0] s0_data,
  input  logic            s0_valid,
  output logic            s0_ready,
  input  logic [2*DW-1:0] s1_data,
  input  logic            s1_valid,
  output logic            s1_ready,
  output logic [2*DW-1:0] fft_din,
  output logic            fft_din_valid,
  input  logic            fft_dout_valid,
  output logic            out_ch,
  output logic            out_sof,
  output logic            out_eof,
  output logic            busy,
  output logic            err_underflow
);

  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [FFT_NUM-1:0] CNT_LAST = {FFT_NUM{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t             state;
  logic [FFT_NUM-1:0] in_cnt;
  logic [FFT_NUM-1:0] out_cnt;
  logic               last_grant;

  logic [CW-1:0]      fifo_cnt;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               tag_mem [TAG_DEPTH];

  logic [2*DW-1:0]    din_hold;

  logic               can_grant;
  logic               grant_any;
  logic               grant_ch;
  logic               fwd;
  logic               push;
  logic               pop;
  logic               fifo_empty;

  // A new frame may only start while a tag slot is free; a pop in the same
  // cycle does not free the slot early.
  assign can_grant  = (fifo_cnt < CW'(TAG_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  // Grant decision and ready generation from the current ownership state.
  always_comb begin
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    grant_any = 1'b0;
    grant_ch  = 1'b0;
    case (state)
      IDLE: begin
        if (can_grant && (s0_valid || s1_valid)) begin
          grant_any = 1'b1;
          // Contention alternates; a lone requester always wins.
          grant_ch  = (s0_valid && s1_valid) ? ~last_grant : s1_valid;
          s0_ready  = ~grant_ch;
          s1_ready  = grant_ch;
        end
      end
      OWN0:    s0_ready = 1'b1;
      OWN1:    s1_ready = 1'b1;
      default: ;
    endcase
  end

  // Input mux: owner sample passes straight through, otherwise hold the last one.
  always_comb begin
    fwd           = (s0_valid && s0_ready) || (s1_valid && s1_ready);
    fft_din_valid = fwd;
    fft_din       = din_hold;
    if (fwd) fft_din = s1_ready ? s1_data : s0_data;
  end

  assign push = grant_any;
  assign pop  = fft_dout_valid && (out_cnt == CNT_LAST) && !fifo_empty;

  // Output labelling comes from the FIFO head and the output beat counter.
  always_comb begin
    out_ch  = fifo_empty ? 1'b0 : tag_mem[rd_ptr];
    out_sof = fft_dout_valid && (out_cnt == '0);
    out_eof = fft_dout_valid && (out_cnt == CNT_LAST);
    busy    = (state != IDLE);
  end

  // Ownership FSM: grant in IDLE, count owner beats, release after beat N-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_cnt     <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            last_grant <= grant_ch;
            in_cnt     <= FFT_NUM'(1);
            state      <= grant_ch ? OWN1 : OWN0;
          end
        end
        OWN0, OWN1: begin
          if (fwd) begin
            if (in_cnt == CNT_LAST) begin
              in_cnt <= '0;
              state  <= IDLE;
            end else begin
              in_cnt <= in_cnt + FFT_NUM'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Hold register so fft_din keeps its last forwarded value between beats.
  always_ff @(posedge clk) begin
    if (rst) din_hold <= '0;
    else if (fwd) din_hold <= fft_din;
  end

  // Tag FIFO: push the owner at grant, pop when the last output beat leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= grant_ch;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Output beat counter and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt       <= '0;
      err_underflow <= 1'b0;
    end else if (fft_dout_valid) begin
      out_cnt <= out_cnt + FFT_NUM'(1);
      if (fifo_empty) err_underflow <= 1'b1;
    end
  end

  // Structural invariants of the arbiter.
  a_one_ready: assert property (@(posedge clk) disable iff (rst)
    !(s0_ready && s1_ready));
  a_fifo_bound: assert property (@(posedge clk) disable iff (rst)
    fifo_cnt <= CW'(TAG_DEPTH));

endmodule

// File: tb/tb_dif_frame_arbiter.sv
// Directed bench for dif_frame_arbiter (N = 64, TAG_DEPTH = 4).
module tb_dif_frame_arbiter;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*DW-1:0] s0_data, s1_data;
  logic          s0_valid, s1_valid;
  logic          s0_ready, s1_ready;
  logic [2*DW-1:0] fft_din;
  logic          fft_din_valid;
  logic          fft_dout_valid;
  logic          out_ch, out_sof, out_eof, busy, err_underflow;

  int n_pass  = 0;
  int n_total = 0;

  dif_frame_arbiter #(.FFT_NUM(6), .DW(DW), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .fft_din(fft_din), .fft_din_valid(fft_din_valid),
    .fft_dout_valid(fft_dout_valid),
    .out_ch(out_ch), .out_sof(out_sof), .out_eof(out_eof),
    .busy(busy), .err_underflow(err_underflow)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    fft_dout_valid = 1'b0;
    s0_data = '0;
    s1_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Distinct, recognisable sample for channel ch, beat k.
  function automatic logic [2*DW-1:0] src(input logic ch, input int k);
    logic [15:0] re, im;
    re = (ch ? 16'hB000 : 16'hA000) + 16'(k);
    im = 16'(k * 3 + (ch ? 7 : 1));
    return {re, im};
  endfunction

  task automatic test_reset();
    logic [7:0] got_v;
    do_reset();
    #3;
    got_v = {s0_ready, s1_ready, fft_din_valid, busy, out_ch, out_sof, out_eof, err_underflow};
    n_total++;
    if (got_v !== 8'h00) $display("FAIL reset_outputs got=%b exp=%b", got_v, 8'h00);
    else n_pass++;
    n_total++;
    if (fft_din !== 32'h0) $display("FAIL reset_fft_din got=%h exp=%h", fft_din, 32'h0);
    else n_pass++;
    tick();
  endtask

  task automatic test_single_channel();
    logic [3:0] got_v, exp_v;
    s0_valid = 1'b1;
    s1_valid = 1'b0;
    for (int c = 0; c < 64; c++) begin
      s0_data = src(0, c);
      s1_data = src(1, c);
      #3;
      got_v = {s0_ready, s1_ready, fft_din_valid, busy};
      exp_v = {1'b1, 1'b0, 1'b1, (c != 0)};
      n_total++;
      if (got_v !== exp_v) $display("FAIL t1_ctrl c=%0d got=%b exp=%b", c, got_v, exp_v);
      else n_pass++;
      n_total++;
      if (fft_din !== src(0, c)) $display("FAIL t1_data c=%0d got=%h exp=%h", c, fft_din, src(0, c));
      else n_pass++;
      tick();
    end
    s0_valid = 1'b0;
    #3;
    got_v = {s0_ready, s1_ready, fft_din_valid, busy};
    n_total++;
    if (got_v !== 4'b0000) $display("FAIL t1_after got=%b exp=%b", got_v, 4'b0000);
    else n_pass++;
    n_total++;
    if (fft_din !== src(0, 63)) $display("FAIL t1_hold got=%h exp=%h", fft_din, src(0, 63));
    else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] got_v, exp_v;
    logic       owner;
    int         idx0, idx1;
    logic [2*DW-1:0] exp_d;
    do_reset();
    idx0 = 0;
    idx1 = 0;
    s0_valid = 1'b1;
    s1_valid = 1'b1;
    for (int c = 0; c < 256; c++) begin
      owner   = ((c / 64) % 2) == 1;
      s0_data = src(0, idx0);
      s1_data = src(1, idx1);
      exp_d   = owner ? src(1, idx1) : src(0, idx0);
      #3;
      got_v = {s0_ready, s1_ready, fft_din_valid, busy};
      exp_v = {!owner, owner, 1'b1, (c % 64) != 0};
      n_total++;
      if (got_v !== exp_v) $display("FAIL t2_ctrl c=%0d got=%b exp=%b", c, got_v, exp_v);
      else n_pass++;
      n_total++;
      if (fft_din !== exp_d) $display("FAIL t2_data c=%0d got=%h exp=%h", c, fft_din, exp_d);
      else n_pass++;
      tick();
      if (owner) idx1++;
      else idx0++;
    end
    // Four frames in flight and no output drained: nothing more may be granted.
    #3;
    got_v = {s0_ready, s1_ready, fft_din_valid, busy};
    n_total++;
    if (got_v !== 4'b0000) $display("FAIL t2_full got=%b exp=%b", got_v, 4'b0000);
    else n_pass++;
    tick();
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    tick();
  endtask

  task automatic test_output_tags();
    logic [2:0] got_v, exp_v;
    fft_dout_valid = 1'b1;
    for (int b = 0; b < 128; b++) begin
      #3;
      got_v = {out_ch, out_sof, out_eof};
      exp_v = {(b >= 64), (b % 64) == 0, (b % 64) == 63};
      n_total++;
      if (got_v !== exp_v) $display("FAIL t5_tags b=%0d got=%b exp=%b", b, got_v, exp_v);
      else n_pass++;
      tick();
    end
    fft_dout_valid = 1'b0;
    #3;
    got_v = {out_sof, out_eof, err_underflow};
    n_total++;
    if (got_v !== 3'b000) $display("FAIL t5_after got=%b exp=%b", got_v, 3'b000);
    else n_pass++;
    tick();
  endtask

  task automatic test_valid_gap();
    logic [3:0] got_v, exp_v;
    logic [2*DW-1:0] exp_d;
    int idx1;
    do_reset();
    idx1 = 0;
    for (int c = 0; c < 69; c++) begin
      s0_valid = (c != 0);
      s1_valid = !(c >= 20 && c < 25);
      s0_data  = src(0, 0);
      s1_data  = src(1, idx1);
      exp_d    = s1_valid ? src(1, idx1) : src(1, idx1 - 1);
      #3;
      got_v = {s0_ready, s1_ready, fft_din_valid, busy};
      exp_v = {1'b0, 1'b1, s1_valid, (c != 0)};
      n_total++;
      if (got_v !== exp_v) $display("FAIL t3_ctrl c=%0d got=%b exp=%b", c, got_v, exp_v);
      else n_pass++;
      n_total++;
      if (fft_din !== exp_d) $display("FAIL t3_data c=%0d got=%h exp=%h", c, fft_din, exp_d);
      else n_pass++;
      tick();
      if (s1_valid) idx1++;
    end
    // Exactly 64 beats were forwarded, so the frame is over and ch0 now wins.
    s1_valid = 1'b0;
    s0_valid = 1'b1;
    #3;
    got_v = {s0_ready, s1_ready, fft_din_valid, busy};
    n_total++;
    if (got_v !== 4'b1010) $display("FAIL t3_release got=%b exp=%b", got_v, 4'b1010);
    else n_pass++;
    tick();
    s0_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [3:0] got_v, exp_v;
    logic [5:0] got_o, exp_o;
    logic       owner;
    int         idx0, idx1;
    do_reset();
    idx0 = 0;
    idx1 = 0;
    s0_valid = 1'b1;
    s1_valid = 1'b1;
    for (int c = 0; c < 260; c++) begin
      owner   = ((c / 64) % 2) == 1;
      s0_data = src(0, idx0);
      s1_data = src(1, idx1);
      #3;
      got_v = {s0_ready, s1_ready, fft_din_valid, busy};
      exp_v = (c < 256) ? {!owner, owner, 1'b1, (c % 64) != 0} : 4'b0000;
      n_total++;
      if (got_v !== exp_v) $display("FAIL t4_fill c=%0d got=%b exp=%b", c, got_v, exp_v);
      else n_pass++;
      tick();
      if (c < 256) begin
        if (owner) idx1++;
        else idx0++;
      end
    end
    // Drain one frame of output; the pop on the last beat frees a slot next cycle.
    fft_dout_valid = 1'b1;
    for (int b = 0; b < 64; b++) begin
      #3;
      got_o = {s0_ready, s1_ready, fft_din_valid, busy, out_ch, out_eof};
      exp_o = {5'b00000, (b == 63)};
      n_total++;
      if (got_o !== exp_o) $display("FAIL t4_drain b=%0d got=%b exp=%b", b, got_o, exp_o);
      else n_pass++;
      tick();
    end
    fft_dout_valid = 1'b0;
    s0_data = src(0, idx0);
    s1_data = src(1, idx1);
    #3;
    got_v = {s0_ready, s1_ready, fft_din_valid, busy};
    n_total++;
    if (got_v !== 4'b1010) $display("FAIL t4_regrant got=%b exp=%b", got_v, 4'b1010);
    else n_pass++;
    n_total++;
    if (fft_din !== src(0, 128)) $display("FAIL t4_regrant_data got=%h exp=%h", fft_din, src(0, 128));
    else n_pass++;
    tick();
    s0_valid = 1'b0;
    s1_valid = 1'b0;
  endtask

  task automatic test_underflow_reset();
    logic [2:0] got_u, exp_u;
    logic [4:0] got_r;
    logic [5:0] got_v, exp_v;
    do_reset();
    fft_dout_valid = 1'b1;
    for (int b = 0; b < 6; b++) begin
      if (b == 3) fft_dout_valid = 1'b0;
      #3;
      got_u = {out_ch, out_sof, err_underflow};
      exp_u = {1'b0, (b == 0), (b != 0)};
      n_total++;
      if (got_u !== exp_u) $display("FAIL t6_underflow b=%0d got=%b exp=%b", b, got_u, exp_u);
      else n_pass++;
      tick();
    end
    // Start a ch0 frame and abandon it at beat 30.
    s0_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      s0_data = src(0, c);
      tick();
    end
    do_reset();
    #3;
    got_r = {busy, err_underflow, s0_ready, s1_ready, fft_din_valid};
    n_total++;
    if (got_r !== 5'b00000) $display("FAIL t6_cleared got=%b exp=%b", got_r, 5'b00000);
    else n_pass++;
    // Both request: ch0 must win again, and the new frame is a full 64 beats.
    for (int r = 0; r < 66; r++) begin
      s0_valid = 1'b1;
      s1_valid = 1'b1;
      s0_data  = src(0, r);
      s1_data  = src(1, r);
      fft_dout_valid = (r >= 1);
      #3;
      got_v = {busy, s0_ready, s1_ready, out_sof, out_ch, err_underflow};
      exp_v = {(r % 64) != 0, (r < 64), (r >= 64), (r == 1 || r == 65), (r == 65), 1'b0};
      n_total++;
      if (got_v !== exp_v) $display("FAIL t6_restart r=%0d got=%b exp=%b", r, got_v, exp_v);
      else n_pass++;
      tick();
    end
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    fft_dout_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    fft_dout_valid = 1'b0;
    s0_data = '0;
    s1_data = '0;
    test_reset();
    test_single_channel();
    test_round_robin();
    test_output_tags();
    test_valid_gap();
    test_backpressure();
    test_underflow_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
